dpdm_line_driver: RTL

Parametrised USB line-side transmitter that turns a serial bitstream (NRZI-encoded packet bits or pre-encoded handshake bits) into differential DP/DM line states. It prepends a configurable SYNC pattern, passes the packet through an elastic bit FIFO and appends a configurable EOP. It ends every packet by draining the FIFO to empty rather than by a fixed count, so packets of any length, including single-byte handshakes, are sent complete. It sits between the NRZI/bit-stuff encoder and the bus pads.

---
 rtl/dpdm_line_driver_if.sv | 25 ++
 rtl/dpdm_line_driver.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/dpdm_line_driver_if.sv
// Bit-stream inputs from the encoder/handshake sources and line-side outputs of the DP/DM driver.
// Handshake: a source bit is transferred on every clock where its *_sending is high; there is no back-pressure.
interface dpdm_line_driver_if;
    logic       nrzi_in_bit;
    logic       nrzi_sending;
    logic       ph_in_bit;
    logic       ph_sending;
    logic       DP;
    logic       DM;
    logic       drive_en;
    logic       busy;
    logic       out_done;
    logic       protocol_err;
    logic [2:0] dbg_state;

    modport master (
        output nrzi_in_bit, nrzi_sending, ph_in_bit, ph_sending,
        input  DP, DM, drive_en, busy, out_done, protocol_err, dbg_state
    );

    modport slave (
        input  nrzi_in_bit, nrzi_sending, ph_in_bit, ph_sending,
        output DP, DM, drive_en, busy, out_done, protocol_err, dbg_state
    );
endinterface

// File: rtl/dpdm_line_driver.sv
// USB line-side transmitter: SYNC prefix, elastic bit FIFO, drain-to-empty, then SE0/J EOP.
// Input-to-line latency is SYNC_LEN+1; the FIFO absorbs the bits that arrive while SYNC is on the line.
module dpdm_line_driver #(
    parameter int          SYNC_LEN       = 8,
    parameter logic [31:0] SYNC_PATTERN   = 32'h0000_002A,
    parameter int          DEPTH          = 16,
    parameter int          EOP_SE0_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    dpdm_line_driver_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SYNC    = 3'd1,
        DATA    = 3'd2,
        DRAIN   = 3'd3,
        EOP_SE0 = 3'd4,
        EOP_J   = 3'd5
    } state_t;

    localparam int              PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              CNT_W     = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [5:0]       SYNC_LAST = 6'(SYNC_LEN);
    localparam logic [2:0]       SE0_LAST  = 3'(EOP_SE0_CYCLES);

    state_t           state;
    logic [5:0]       sync_cnt;
    logic [2:0]       se0_cnt;
    logic             closed;

    logic [DEPTH-1:0] mem;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic in_valid;
    logic in_bit;
    logic fifo_empty;
    logic fifo_full;
    logic head;
    logic accepting;
    logic sync_done;
    logic push;
    logic pop;
    logic err_now;

    // nrzi wins when both sources claim the same cycle
    always_comb begin
        in_valid   = bus.nrzi_sending | bus.ph_sending;
        in_bit     = bus.nrzi_sending ? bus.nrzi_in_bit : bus.ph_in_bit;
        fifo_empty = (count == '0);
        fifo_full  = (count == FULL_CNT);
        head       = mem[rd_ptr];
        accepting  = (state == IDLE) || (state == SYNC) || (state == DATA);
        sync_done  = (state == SYNC) && (sync_cnt == SYNC_LAST);
        pop        = sync_done || (((state == DATA) || (state == DRAIN)) && !fifo_empty);
        push       = in_valid && accepting && (!fifo_full || pop);
        err_now    = (in_valid && !accepting)
                   || (in_valid && accepting && fifo_full && !pop)
                   || (bus.nrzi_sending && bus.ph_sending);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_bit;
                wr_ptr      <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Outputs are loaded with what the line shows in the state being entered.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            sync_cnt         <= '0;
            se0_cnt          <= '0;
            closed           <= 1'b0;
            bus.DP           <= 1'b0;
            bus.DM           <= 1'b0;
            bus.drive_en     <= 1'b0;
            bus.busy         <= 1'b0;
            bus.out_done     <= 1'b0;
            bus.protocol_err <= 1'b0;
        end else begin
            bus.out_done <= 1'b0;
            if (err_now) begin
                bus.protocol_err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state        <= SYNC;
                        sync_cnt     <= 6'd1;
                        closed       <= 1'b0;
                        bus.DP       <= SYNC_PATTERN[0];
                        bus.DM       <= ~SYNC_PATTERN[0];
                        bus.drive_en <= 1'b1;
                        bus.busy     <= 1'b1;
                    end else begin
                        bus.DP       <= 1'b0;
                        bus.DM       <= 1'b0;
                        bus.drive_en <= 1'b0;
                        bus.busy     <= 1'b0;
                    end
                end
                SYNC: begin
                    if (!in_valid) begin
                        closed <= 1'b1;
                    end
                    if (!sync_done) begin
                        sync_cnt <= sync_cnt + 6'd1;
                        bus.DP   <= SYNC_PATTERN[sync_cnt[4:0]];
                        bus.DM   <= ~SYNC_PATTERN[sync_cnt[4:0]];
                    end else begin
                        bus.DP <= head;
                        bus.DM <= ~head;
                        state  <= (closed || !in_valid) ? DRAIN : DATA;
                    end
                end
                DATA, DRAIN: begin
                    if (!fifo_empty) begin
                        bus.DP <= head;
                        bus.DM <= ~head;
                        if ((state == DRAIN) || !in_valid) begin
                            state <= DRAIN;
                        end
                    end else begin
                        state   <= EOP_SE0;
                        se0_cnt <= 3'd1;
                        bus.DP  <= 1'b0;
                        bus.DM  <= 1'b0;
                    end
                end
                EOP_SE0: begin
                    if (se0_cnt != SE0_LAST) begin
                        se0_cnt <= se0_cnt + 3'd1;
                    end else begin
                        state        <= EOP_J;
                        bus.DP       <= 1'b1;
                        bus.DM       <= 1'b0;
                        bus.out_done <= 1'b1;
                    end
                end
                EOP_J: begin
                    state        <= IDLE;
                    bus.DP       <= 1'b0;
                    bus.DM       <= 1'b0;
                    bus.drive_en <= 1'b0;
                    bus.busy     <= 1'b0;
                end
                default: begin
                    state        <= IDLE;
                    bus.DP       <= 1'b0;
                    bus.DM       <= 1'b0;
                    bus.drive_en <= 1'b0;
                    bus.busy     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dbg_state = state;

endmodule
